// File: rtl/index_packer_if.sv
// Stream bundle for the index packer: the index input stream and the packed
// word output stream. The packer takes the slave view. The producer/consumer
// environment takes the master view.
interface index_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] s_idx_tdata;
  logic                  s_idx_tvalid;
  logic                  s_idx_tready;
  logic [OUT_WIDTH-1:0]  m_pack_tdata;
  logic                  m_pack_tvalid;
  logic                  m_pack_tready;
  logic                  m_pack_tlast;

  modport slave (
    input  s_idx_tdata,
    input  s_idx_tvalid,
    output s_idx_tready,
    output m_pack_tdata,
    output m_pack_tvalid,
    input  m_pack_tready,
    output m_pack_tlast
  );

  modport master (
    output s_idx_tdata,
    output s_idx_tvalid,
    input  s_idx_tready,
    input  m_pack_tdata,
    input  m_pack_tvalid,
    output m_pack_tready,
    input  m_pack_tlast
  );
endinterface

// File: rtl/index_packer.sv
// Index packer: packs the low IDX_BITS of each quantizer index LSB-first into
// OUT_WIDTH-bit words. Each frame of FRAME_LEN indices starts on a word
// boundary. A partial tail word is flushed zero-padded and carries tlast.
// Indices at or above CODEBOOK_LENGTH raise a sticky range error but are still
// packed (truncated).
module index_packer #(
  parameter int DATA_WIDTH      = 16,
  parameter int CODEBOOK_LENGTH = 1000,
  parameter int IDX_BITS        = $clog2(CODEBOOK_LENGTH),
  parameter int OUT_WIDTH       = 32,
  parameter int FRAME_LEN       = 64
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  index_packer_if.slave bus,
  output logic          err_range_o
);

  // Buffer holds up to OUT_WIDTH-1 leftover bits plus one fresh index.
  localparam int BUF_W  = OUT_WIDTH + IDX_BITS;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [FILL_W-1:0]   OUT_FILL = FILL_W'(OUT_WIDTH);
  localparam logic [FILL_W-1:0]   IDX_FILL = FILL_W'(IDX_BITS);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [DATA_WIDTH:0] CB_LIMIT = (DATA_WIDTH + 1)'(CODEBOOK_LENGTH);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t               state_p0, state_n;
  logic [BUF_W-1:0]     bit_buf_p0, bit_buf_n;
  logic [FILL_W-1:0]    fill_p0, fill_n;
  logic [CNT_W-1:0]     cnt_p0, cnt_n;
  logic [OUT_WIDTH-1:0] out_data_p1;
  logic                 out_last_p1;
  logic                 vld_p1;
  logic                 err_p0;

  logic                 out_free;
  logic                 s_ready;
  logic                 accept;
  logic [BUF_W-1:0]     merged;
  logic [FILL_W-1:0]    fill_acc;
  logic                 load;
  logic [OUT_WIDTH-1:0] load_data;
  logic                 load_last;

  // The output register can take a new word when empty or being drained now.
  assign out_free = !vld_p1 || bus.m_pack_tready;
  // Reset term keeps tready low while reset is held, independent of the clock.
  assign s_ready  = rst_n_i && (state_p0 == ST_RUN) && out_free;
  assign accept   = bus.s_idx_tvalid && s_ready;

  assign bus.s_idx_tready  = s_ready;
  assign bus.m_pack_tdata  = out_data_p1;
  assign bus.m_pack_tvalid = vld_p1;
  assign bus.m_pack_tlast  = out_last_p1;
  assign err_range_o       = err_p0;

  // Next-state: pack accepted index, emit full words, and handle the frame tail.
  always_comb begin
    state_n   = state_p0;
    bit_buf_n = bit_buf_p0;
    fill_n    = fill_p0;
    cnt_n     = cnt_p0;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    merged    = bit_buf_p0 | (BUF_W'(bus.s_idx_tdata[IDX_BITS-1:0]) << fill_p0);
    fill_acc  = fill_p0 + IDX_FILL;

    case (state_p0)
      ST_RUN: begin
        if (accept) begin
          if (fill_acc >= OUT_FILL) begin
            load      = 1'b1;
            load_data = merged[OUT_WIDTH-1:0];
            bit_buf_n = merged >> OUT_WIDTH;
            fill_n    = fill_acc - OUT_FILL;
          end else begin
            bit_buf_n = merged;
            fill_n    = fill_acc;
          end

          if (cnt_p0 == CNT_LAST) begin
            cnt_n = '0;
            // A frame ending exactly on a word boundary tags that word as last.
            // Otherwise the leftover bits go out as a padded tail word.
            if (fill_n == '0) begin
              load_last = 1'b1;
            end else begin
              state_n = ST_FLUSH;
            end
          end else begin
            cnt_n = cnt_p0 + CNT_W'(1);
          end
        end
      end

      ST_FLUSH: begin
        // Bits above fill are always zero, so the low word is already padded.
        if (out_free) begin
          load      = 1'b1;
          load_data = bit_buf_p0[OUT_WIDTH-1:0];
          load_last = 1'b1;
          bit_buf_n = '0;
          fill_n    = '0;
          state_n   = ST_RUN;
        end
      end

      default: state_n = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_p0 <= ST_RUN;
    end else begin
      state_p0 <= state_n;
    end
  end

  // Bit buffer, fill level and frame index counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_buf_p0 <= '0;
      fill_p0    <= '0;
      cnt_p0     <= '0;
    end else begin
      bit_buf_p0 <= bit_buf_n;
      fill_p0    <= fill_n;
      cnt_p0     <= cnt_n;
    end
  end

  // Output word register: load replaces, drain clears valid, stall holds.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
      out_last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1      <= 1'b1;
      out_data_p1 <= load_data;
      out_last_p1 <= load_last;
    end else if (bus.m_pack_tready) begin
      vld_p1      <= 1'b0;
    end
  end

  // Sticky out-of-codebook flag, checked on the full input word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_p0 <= 1'b0;
    end else if (accept && ({1'b0, bus.s_idx_tdata} >= CB_LIMIT)) begin
      err_p0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_index_packer.sv
// Bench for index_packer. It uses directed frames with known words, a
// FRAME_LEN=16 instance, async reset pulses, and a randomized handshake run.
// A bit-queue reference model checks the randomized run.
module tb_index_packer;
  localparam int DW = 16;
  localparam int OW = 32;
  localparam int IB = 10;
  localparam int CB = 1000;

  logic clk = 1'b0;
  logic rst_n;
  logic err4;
  logic err16;

  index_packer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus4 ();
  index_packer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus16 ();

  index_packer #(
    .DATA_WIDTH(DW), .CODEBOOK_LENGTH(CB), .IDX_BITS(IB), .OUT_WIDTH(OW), .FRAME_LEN(4)
  ) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus4), .err_range_o(err4)
  );

  index_packer #(
    .DATA_WIDTH(DW), .CODEBOOK_LENGTH(CB), .IDX_BITS(IB), .OUT_WIDTH(OW), .FRAME_LEN(16)
  ) dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus16), .err_range_o(err16)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: indices of the current frame and the expected words.
  logic [15:0] frame_q[$];
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Concatenate the frame's index bits LSB-first, then cut them into words.
  // The last word is zero-padded and flagged last.
  task automatic model_frame();
    bit bits[$];
    logic [31:0] w;
    foreach (frame_q[i])
      for (int b = 0; b < IB; b++) bits.push_back(frame_q[i][b]);
    frame_q.delete();
    while (bits.size() > 0) begin
      w = '0;
      for (int b = 0; b < OW; b++)
        if (bits.size() > 0) w[b] = bits.pop_front();
      exp_q.push_back(w);
      exp_last_q.push_back(bits.size() == 0);
    end
  endtask

  task automatic feed4(input logic [15:0] d);
    bus4.s_idx_tvalid = 1'b1;
    bus4.s_idx_tdata  = d;
    @(negedge clk);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_vld"},    bus4.m_pack_tvalid, 0);
    chk({tag, "_data"},   bus4.m_pack_tdata,  0);
    chk({tag, "_last"},   bus4.m_pack_tlast,  0);
    chk({tag, "_err"},    err4,               0);
    chk({tag, "_tready"}, bus4.s_idx_tready,  0);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          frames_done;
    int          n_words;
    logic        stalled;
    logic        rdy_low;
    logic [31:0] hold_d;
    logic        hold_l;

    bus4.s_idx_tvalid  = 1'b0;
    bus4.s_idx_tdata   = '0;
    bus4.m_pack_tready = 1'b0;
    bus16.s_idx_tvalid  = 1'b0;
    bus16.s_idx_tdata   = '0;
    bus16.m_pack_tready = 1'b0;

    // Power-on reset with a real falling edge, observed before any clock edge.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_vld",    bus4.m_pack_tvalid, 0);
    chk("rst_data",   bus4.m_pack_tdata,  0);
    chk("rst_last",   bus4.m_pack_tlast,  0);
    chk("rst_err",    err4,               0);
    chk("rst_tready", bus4.s_idx_tready,  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_tready",   bus4.s_idx_tready,  1);
    chk("post_rst_tready16", bus16.s_idx_tready, 1);

    // Frame 1,2,3,0x3FF with a free-running sink.
    bus4.m_pack_tready = 1'b1;
    feed4(16'd1); feed4(16'd2); feed4(16'd3); feed4(16'h3FF);
    bus4.s_idx_tvalid = 1'b0;
    chk("b2b_w0_vld",    bus4.m_pack_tvalid, 1);
    chk("b2b_w0_data",   bus4.m_pack_tdata,  32'hC0300801);
    chk("b2b_w0_last",   bus4.m_pack_tlast,  0);
    chk("b2b_flush_rdy", bus4.s_idx_tready,  0);
    @(negedge clk);
    chk("b2b_w1_vld",  bus4.m_pack_tvalid, 1);
    chk("b2b_w1_data", bus4.m_pack_tdata,  32'h000000FF);
    chk("b2b_w1_last", bus4.m_pack_tlast,  1);
    @(negedge clk);
    chk("b2b_idle_vld", bus4.m_pack_tvalid, 0);

    // Same frame while the sink stalls for five cycles after the first word.
    bus4.m_pack_tready = 1'b0;
    feed4(16'd1); feed4(16'd2); feed4(16'd3); feed4(16'h3FF);
    bus4.s_idx_tvalid = 1'b0;
    chk("stall_w0_data", bus4.m_pack_tdata, 32'hC0300801);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold_vld",  bus4.m_pack_tvalid, 1);
      chk("stall_hold_data", bus4.m_pack_tdata,  32'hC0300801);
      chk("stall_hold_last", bus4.m_pack_tlast,  0);
      chk("stall_tready",    bus4.s_idx_tready,  0);
    end
    bus4.m_pack_tready = 1'b1;
    #1;
    chk("stall_release_tready", bus4.s_idx_tready, 0);
    @(negedge clk);
    chk("stall_w1_vld",  bus4.m_pack_tvalid, 1);
    chk("stall_w1_data", bus4.m_pack_tdata,  32'h000000FF);
    chk("stall_w1_last", bus4.m_pack_tlast,  1);
    @(negedge clk);
    chk("stall_idle_vld", bus4.m_pack_tvalid, 0);

    // FRAME_LEN=16 instance: 16 x 0x155 fills exactly five words, no flush.
    frame_q.delete(); exp_q.delete(); exp_last_q.delete();
    for (int i = 0; i < 16; i++) frame_q.push_back(16'h155);
    model_frame();
    n_words = 0;
    rdy_low = 1'b0;
    bus16.m_pack_tready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus16.s_idx_tvalid = (i < 16);
      bus16.s_idx_tdata  = 16'h155;
      @(negedge clk);
      if (!bus16.s_idx_tready) rdy_low = 1'b1;
      if (bus16.m_pack_tvalid) begin
        if (n_words < 5) begin
          chk("f16_word", bus16.m_pack_tdata, exp_q[n_words]);
          chk("f16_last", bus16.m_pack_tlast, exp_last_q[n_words]);
        end
        n_words++;
      end
    end
    bus16.s_idx_tvalid = 1'b0;
    chk("f16_word_count", n_words, 5);
    chk("f16_no_flush",   rdy_low, 0);
    chk("f16_err",        err16,   0);
    exp_q.delete(); exp_last_q.delete();

    // Out-of-range index 1005 raises the sticky flag and is still packed.
    bus4.m_pack_tready = 1'b1;
    feed4(16'd1005);
    chk("range_err_set", err4, 1);
    feed4(16'd0); feed4(16'd0); feed4(16'd0);
    bus4.s_idx_tvalid = 1'b0;
    chk("range_w0_data", bus4.m_pack_tdata, 32'h000003ED);
    chk("range_w0_last", bus4.m_pack_tlast, 0);
    @(negedge clk);
    chk("range_w1_data", bus4.m_pack_tdata, 32'h00000000);
    chk("range_w1_last", bus4.m_pack_tlast, 1);
    @(negedge clk);

    // Random valid/ready over 100 frames against the bit-queue model.
    frame_q.delete(); exp_q.delete(); exp_last_q.delete();
    cyc = 0;
    frames_done = 0;
    stalled = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    while (frames_done < 100 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("rand_hold_vld",  bus4.m_pack_tvalid, 1);
        chk("rand_hold_data", bus4.m_pack_tdata,  hold_d);
        chk("rand_hold_last", bus4.m_pack_tlast,  hold_l);
      end
      bus4.s_idx_tvalid  = ($urandom_range(0, 99) < 60);
      bus4.s_idx_tdata   = 16'($urandom_range(0, CB - 1));
      bus4.m_pack_tready = ($urandom_range(0, 99) < 60);
      #1;
      if (bus4.m_pack_tvalid && bus4.m_pack_tready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_word", bus4.m_pack_tdata, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          hold_l = exp_last_q.pop_front();
          chk("rand_word", bus4.m_pack_tdata, exp_q.pop_front());
          chk("rand_last", bus4.m_pack_tlast, hold_l);
          if (hold_l) frames_done++;
        end
      end
      if (bus4.s_idx_tvalid && bus4.s_idx_tready) begin
        frame_q.push_back(bus4.s_idx_tdata);
        if (frame_q.size() == 4) model_frame();
      end
      stalled = bus4.m_pack_tvalid && !bus4.m_pack_tready;
      hold_d  = bus4.m_pack_tdata;
      hold_l  = bus4.m_pack_tlast;
    end
    chk("rand_frames_done", frames_done, 100);
    chk("range_err_sticky", err4, 1);
    bus4.s_idx_tvalid  = 1'b0;
    bus4.m_pack_tready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset after arbitrary leftover state, clearing the sticky flag.
    pulse_reset("rst_a");
    chk("rst_a_tready", bus4.s_idx_tready,  1);
    chk("rst_a_vld",    bus4.m_pack_tvalid, 0);

    // Reset while a word is held and the tail is waiting to flush.
    bus4.m_pack_tready = 1'b0;
    feed4(16'd1); feed4(16'd2); feed4(16'd3); feed4(16'h3FF);
    bus4.s_idx_tvalid = 1'b0;
    chk("rst_b_pre_vld", bus4.m_pack_tvalid, 1);
    pulse_reset("rst_b");
    bus4.m_pack_tready = 1'b1;

    // Reset two indices into a frame.
    feed4(16'd7); feed4(16'd8);
    bus4.s_idx_tvalid = 1'b0;
    pulse_reset("rst_c");

    // A fresh frame after the resets must reproduce the reference words.
    feed4(16'd1); feed4(16'd2); feed4(16'd3); feed4(16'h3FF);
    bus4.s_idx_tvalid = 1'b0;
    chk("post_rst_w0_data", bus4.m_pack_tdata, 32'hC0300801);
    chk("post_rst_w0_last", bus4.m_pack_tlast, 0);
    @(negedge clk);
    chk("post_rst_w1_data", bus4.m_pack_tdata, 32'h000000FF);
    chk("post_rst_w1_last", bus4.m_pack_tlast, 1);
    @(negedge clk);
    chk("post_rst_idle_vld", bus4.m_pack_tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
